// File: rtl/load_store_unit.sv
// Load/store unit between the CPU datapath and a word-organised data memory:
// sub-word load extraction, read-modify-write sub-word stores, sticky fault capture.
module load_store_unit #(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  input  logic        fault_clr,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Any set bit in this mask puts the access outside the addressable range.
  localparam logic [31:0] RANGE_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] saved_addr_q, saved_addr_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        is_b, is_h, is_w, legal;
  logic        misaligned, out_of_range, bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    is_b         = (funct3 == F3_B) || (funct3 == F3_BU);
    is_h         = (funct3 == F3_H) || (funct3 == F3_HU);
    is_w         = (funct3 == F3_W);
    legal        = is_b || is_h || is_w;
    misaligned   = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
    out_of_range = |(addr & RANGE_MASK);
    bad          = !legal || misaligned || out_of_range;
  end

  always_comb begin
    case (addr[1:0])
      2'd0:    lane_byte = mem_RD[7:0];
      2'd1:    lane_byte = mem_RD[15:8];
      2'd2:    lane_byte = mem_RD[23:16];
      default: lane_byte = mem_RD[31:24];
    endcase
    lane_half = addr[1] ? mem_RD[31:16] : mem_RD[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'd0, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'd0, lane_half};
      default: load_data = mem_RD;
    endcase
  end

  always_comb begin
    merged = mem_RD;
    if (is_b) begin
      case (addr[1:0])
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (addr[1]) begin
      merged[31:16] = wdata[15:0];
    end else begin
      merged[15:0] = wdata[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    saved_addr_d = saved_addr_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    stall        = 1'b0;
    rdata        = '0;
    mem_A        = addr;
    mem_WD       = '0;
    mem_WE       = 1'b0;

    if (fault_clr) begin
      fault_d      = 1'b0;
      fault_addr_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad) begin
            // A clear in the same cycle does not hide a new fault.
            if (!fault_q || fault_clr) begin
              fault_d      = 1'b1;
              fault_addr_d = addr;
            end
          end else if (!we) begin
            rdata = load_data;
          end else if (is_w) begin
            mem_WE = 1'b1;
            mem_WD = wdata;
          end else begin
            stall        = 1'b1;
            merge_d      = merged;
            saved_addr_d = {addr[31:2], 2'b00};
            state_d      = WRITE;
          end
        end
      end
      WRITE: begin
        mem_A   = saved_addr_q;
        mem_WD  = merge_q;
        mem_WE  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      saved_addr_q <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      saved_addr_q <= saved_addr_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath and the word-organised, byte-addressed data memory.
- Memory read is combinational on the word-aligned address; memory write is a full 32-bit word on posedge clk when WE is high.
- This block handles sub-word loads (lb/lh/lbu/lhu) by lane extraction and extension.
- Sub-word stores (sb/sh) use a two-cycle read-modify-write with a CPU stall. The block also detects misaligned, illegal and out-of-range accesses and records them in a sticky fault register.

Parameters:
- ADDR_BITS, 16: memory byte-address width. An access with any addr bit at or above ADDR_BITS set is out of range.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 1: CPU memory access valid this cycle.
- we, input, 1: 1 = store, 0 = load.
- funct3, input, 3: 000 b, 001 h, 010 w, 100 bu, 101 hu. All other codes are illegal.
- addr, input, 32: CPU byte address.
- wdata, input, 32: store data, right-aligned.
- rdata, output, 32: extended load result (combinational).
- stall, output, 1: CPU must hold its PC and inputs this cycle.
- fault_clr, input, 1: synchronous clear of the fault register.
- fault, output, 1: sticky fault flag.
- fault_addr, output, 32: addr of the first faulting access since the last clear.
- mem_A, output, 32: memory address.
- mem_WD, output, 32: memory write data.
- mem_WE, output, 1: memory write enable.
- mem_RD, input, 32: memory read data. Byte i of the word is on bits 8i+7:8i (little-endian).

Behaviour:
- States: IDLE, WRITE. Reset puts the block in IDLE and clears the merge register, saved address, fault and fault_addr to 0.
- Combinational outputs with req=0: stall=0, mem_WE=0, rdata=0.

Access classification (combinational):
- bad = illegal funct3, OR h/hu with addr[0]=1, OR w with addr[1:0]!=0, OR addr out of range.
- A bad access with req=1: mem_WE=0, rdata=0, stall=0, and no state change.
  - At the next edge, if fault=0: fault<=1 and fault_addr<=addr.
  - If fault is already 1, fault_addr keeps the first faulting address.
- fault_clr=1 clears fault and fault_addr at the edge. If fault_clr and a new bad access occur in the same cycle, the new fault wins (fault=1, fault_addr=new addr).

Loads (IDLE only, always 0 cycles of stall):
- mem_A = addr. The lane is selected by addr[1:0] (h uses addr[1]).
- b/h sign-extend; bu/hu zero-extend; w passes through.

Word store (sw):
- In IDLE: mem_A=addr, mem_WD=wdata, mem_WE=1, stall=0. The write lands at this edge and the state stays IDLE.

Sub-word store (sb/sh), IDLE cycle:
- Outputs: mem_A=addr, mem_WE=0, stall=1.
- At the edge:
  - merge <= mem_RD with the selected lane(s) replaced by wdata[7:0] or wdata[15:0].
  - saved_addr <= {addr[31:2], 2'b00}.
  - Next state is WRITE.

Sub-word store (sb/sh), WRITE cycle:
- Outputs: mem_A=saved_addr, mem_WD=merge, mem_WE=1, stall=0.
- CPU inputs are ignored in this cycle. The CPU re-presents the same store and the block completes it rather than restarting.
- Next state is IDLE unconditionally.
- Total latency is 2 cycles; the memory word is updated at the end of the WRITE cycle.

Other rules:
- mem_WD=0 whenever mem_WE=0.
- Reset asserted during WRITE returns the block to IDLE immediately. mem_WE drops asynchronously and the write is lost; memory holds its pre-store value.
- Back-to-back sub-word stores take 2 cycles each with no bubble beyond the stall.
- A load immediately after a sub-word store observes the merged word.

Test Plan:
- Memory word 0x10 = 0x11223344; lb 0x12 -> rdata 0x00000022; lbu 0x13 -> 0x00000011; lh 0x12 -> 0x00001122; lw 0x10 -> 0x11223344. stall=0 throughout.
- sb addr 0x12, wdata 0x000000AB:
  - Cycle 1: stall=1, mem_WE=0.
  - Cycle 2: mem_A=0x10, mem_WD=0x11AB3344, mem_WE=1.
  - Afterwards lb 0x12 -> 0xFFFFFFAB.
- sw 0x20, 0xDEADBEEF -> mem_WE=1 same cycle, stall=0. Then lhu 0x22 -> 0x0000DEAD and lh 0x22 -> 0xFFFFDEAD.
- lh 0x11 -> mem_WE=0, rdata=0, then fault=1 and fault_addr=0x11. A following sw 0x22 leaves fault_addr=0x11. fault_clr=1 -> fault=0, fault_addr=0.
- sh 0x16, wdata 0x0000CAFE over word 0x14 = 0x12345678: assert rst_n=0 during the WRITE cycle -> mem_WE=0 immediately, state IDLE, word 0x14 still 0x12345678.
- funct3=011 and sw to 0x00010000 (ADDR_BITS=16) -> each sets fault with no memory write.
